// File: rtl/p405s_trc_fifo_ctl_pkg.sv
// Shared constants and types for the trace FIFO sequencing controller.
package p405s_trc_pkg;

  localparam int TRC_DEPTH = 16;
  localparam int TRC_AW    = 4;
  localparam int TRC_CNT_W = 5;

  localparam logic [TRC_AW-1:0]    TRC_PTR_RST  = '0;
  localparam logic [TRC_AW-1:0]    TRC_PTR_ONE  = TRC_AW'(1);
  localparam logic [TRC_CNT_W-1:0] TRC_CNT_RST  = '0;
  localparam logic [TRC_CNT_W-1:0] TRC_CNT_ONE  = TRC_CNT_W'(1);
  localparam logic [TRC_CNT_W-1:0] TRC_CNT_FULL = TRC_CNT_W'(TRC_DEPTH);

  // Occupancy state, tracked alongside the count for debug visibility.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } trc_occ_e;

endpackage

// File: rtl/p405s_trc_fifo_ctl_if.sv
// Push/pop control and status bundle between the trace FIFO controller
// and its pusher/popper/datapath neighbours.
//
// Handshake: trcPush is a request that is taken in the same CB edge when
// accepted (trcFifoE1 then carries exactly one set bit); trcPop consumes the
// word on the datapath output and is only honoured while trcFifoRdValid is 1.
// A pop with trcFifoRdValid low is ignored. trcClear overrides both.
interface p405s_trc_fifo_ctl_if;
  import p405s_trc_pkg::*;

  logic                   trcClear;
  logic                   trcWrapMode;
  logic                   trcFreeze;
  logic                   trcPush;
  logic                   trcPop;
  logic [0:TRC_DEPTH-1]   trcFifoE1;
  logic [0:TRC_AW-1]      fifoRdAddrL2;
  logic                   trcFifoEmpty;
  logic                   trcFifoFull;
  logic [0:TRC_CNT_W-1]   trcFifoCount;
  logic                   trcFifoRdValid;
  logic                   trcFifoOvf;
  trc_occ_e               trcOccState;

  modport master (
    output trcClear, trcWrapMode, trcFreeze, trcPush, trcPop,
    input  trcFifoE1, fifoRdAddrL2, trcFifoEmpty, trcFifoFull,
           trcFifoCount, trcFifoRdValid, trcFifoOvf, trcOccState
  );

  modport slave (
    input  trcClear, trcWrapMode, trcFreeze, trcPush, trcPop,
    output trcFifoE1, fifoRdAddrL2, trcFifoEmpty, trcFifoFull,
           trcFifoCount, trcFifoRdValid, trcFifoOvf, trcOccState
  );

endinterface

// File: rtl/p405s_trc_onehot_dec.sv
// Pointer to one-hot line-enable decoder; big-endian output, bit i = line i.
module p405s_trc_onehot_dec
  import p405s_trc_pkg::*;
#(
  parameter int DEPTH = TRC_DEPTH,
  parameter int AW    = TRC_AW
) (
  input  logic [AW-1:0]    ptr,
  input  logic             en,
  output logic [0:DEPTH-1] oneHot
);

  // Single set bit at the pointed line, all zero when disabled.
  always_comb begin
    oneHot = '0;
    if (en) oneHot[ptr] = 1'b1;
  end

endmodule

// File: rtl/p405s_trc_fifo_ctl.sv
// Trace FIFO sequencing controller: owns write/read pointers, occupancy
// count and overflow status for the 16-line trace datapath.
module p405s_trc_fifo_ctl
  import p405s_trc_pkg::*;
(
  input  logic                  CB,
  input  logic                  resetL,
  p405s_trc_fifo_ctl_if.slave   trc
);

  logic [TRC_AW-1:0]    wrPtr;
  logic [TRC_AW-1:0]    rdPtr;
  logic [TRC_CNT_W-1:0] count;
  logic [TRC_CNT_W-1:0] countNext;
  logic                 ovf;
  trc_occ_e             occState;

  logic full;
  logic empty;
  logic pushLive;
  logic popAcc;
  logic pushAcc;
  logic overwrite;
  logic dropped;

  assign full  = (count == TRC_CNT_FULL);
  assign empty = (count == TRC_CNT_RST);

  // A push that is neither frozen nor cleared; whether it lands depends on room.
  assign pushLive  = trc.trcPush & ~trc.trcFreeze & ~trc.trcClear;
  assign popAcc    = trc.trcPop & ~empty & ~trc.trcClear;
  assign pushAcc   = pushLive & (~full | trc.trcWrapMode | popAcc);
  // Full with no simultaneous pop: either the oldest line is overwritten
  // (wrap mode) or the word is dropped. Both are overflow events.
  assign overwrite = pushAcc & full & ~popAcc;
  assign dropped   = pushLive & ~pushAcc;

  // Occupancy after this edge; an overwrite leaves the count at full.
  always_comb begin
    countNext = count;
    if (pushAcc && !popAcc && !full) countNext = count + TRC_CNT_ONE;
    else if (popAcc && !pushAcc)     countNext = count - TRC_CNT_ONE;
  end

  // Pointer, count, sticky overflow and occupancy-state registers.
  always_ff @(posedge CB or negedge resetL) begin
    if (!resetL) begin
      wrPtr    <= TRC_PTR_RST;
      rdPtr    <= TRC_PTR_RST;
      count    <= TRC_CNT_RST;
      ovf      <= 1'b0;
      occState <= OCC_EMPTY;
    end else if (trc.trcClear) begin
      wrPtr    <= TRC_PTR_RST;
      rdPtr    <= TRC_PTR_RST;
      count    <= TRC_CNT_RST;
      ovf      <= 1'b0;
      occState <= OCC_EMPTY;
    end else begin
      if (pushAcc)             wrPtr <= wrPtr + TRC_PTR_ONE;
      if (popAcc || overwrite) rdPtr <= rdPtr + TRC_PTR_ONE;
      count <= countNext;
      if (overwrite || dropped) ovf <= 1'b1;
      case (occState)
        OCC_EMPTY:   if (pushAcc) occState <= OCC_PARTIAL;
        OCC_PARTIAL: begin
          if (countNext == TRC_CNT_FULL)     occState <= OCC_FULL;
          else if (countNext == TRC_CNT_RST) occState <= OCC_EMPTY;
        end
        OCC_FULL:    if (popAcc && !pushAcc) occState <= OCC_PARTIAL;
        default:     occState <= OCC_EMPTY;
      endcase
    end
  end

  // Write enables are forced off while reset is asserted.
  p405s_trc_onehot_dec #(
    .DEPTH (TRC_DEPTH),
    .AW    (TRC_AW)
  ) u_wrDec (
    .ptr    (wrPtr),
    .en     (pushAcc & resetL),
    .oneHot (trc.trcFifoE1)
  );

  assign trc.fifoRdAddrL2   = rdPtr;
  assign trc.trcFifoCount   = count;
  assign trc.trcFifoEmpty   = empty;
  assign trc.trcFifoFull    = full;
  assign trc.trcFifoRdValid = ~empty;
  assign trc.trcFifoOvf     = ovf;
  assign trc.trcOccState    = occState;

endmodule
